uart_frame_bridge: RTL and testbench

//  Parametrised byte<->frame bridge between the UART receiver/transmitter pair and core logic.
//  RX side packs NBYTES received bytes into one frame word; an inter-byte timeout discards partial frames.
//  TX side serialises a frame word into NBYTES transmitter handshakes.

---
 rtl/uart_frame_bridge_if.sv | 34 +++
 rtl/uart_frame_bridge.sv | 180 ++++++++++++++++++
 tb/tb_uart_frame_bridge.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_bridge_if.sv
// Byte/frame handshake bundle between the UART bridge and its surroundings.
// The slave modport is the bridge's view; master is the core/UART side.
interface uart_frame_bridge_if #(
  parameter int NBYTES = 8
) ();
  localparam int CW = $clog2(NBYTES + 1);

  logic                  rx_strobe;
  logic [7:0]            rx_byte;
  logic [NBYTES*8-1:0]   frame_data;
  logic                  frame_valid;
  logic                  frame_err;
  logic [CW-1:0]         rx_count;
  logic                  loopback;
  logic [NBYTES*8-1:0]   tx_frame_data;
  logic                  tx_frame_valid;
  logic                  tx_frame_ready;
  logic [7:0]            tx_byte;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  lb_overflow;

  modport slave (
    input  rx_strobe, rx_byte, loopback, tx_frame_data, tx_frame_valid, tx_busy,
    output frame_data, frame_valid, frame_err, rx_count, tx_frame_ready,
           tx_byte, tx_start, lb_overflow
  );

  modport master (
    output rx_strobe, rx_byte, loopback, tx_frame_data, tx_frame_valid, tx_busy,
    input  frame_data, frame_valid, frame_err, rx_count, tx_frame_ready,
           tx_byte, tx_start, lb_overflow
  );
endinterface

// File: rtl/uart_frame_bridge.sv
// Packs received UART bytes into NBYTES-wide frames, serialises frames back out
// to the transmitter, and optionally loops received frames back through a 1-deep buffer.
module uart_frame_bridge #(
  parameter int NBYTES      = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter bit MSB_FIRST   = 1'b0
) (
  input logic clk,
  input logic rst,
  uart_frame_bridge_if.slave bus
);
  localparam int FW = NBYTES * 8;
  localparam int CW = $clog2(NBYTES + 1);
  localparam int XW = $clog2(NBYTES);

  // Byte position within a frame -> lane index inside the frame word.
  function automatic int lane_of(input int pos);
    return MSB_FIRST ? (NBYTES - 1 - pos) : pos;
  endfunction

  // ---------------------------------------------------------------- RX
  logic [FW-1:0] acc;
  logic [FW-1:0] acc_next;
  logic          rx_last;
  logic          rx_done;
  logic          expire;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc;
    acc_next[8*lane_of(int'(bus.rx_count)) +: 8] = bus.rx_byte;
  end

  assign rx_last = (bus.rx_count == CW'(NBYTES - 1));
  assign rx_done = bus.rx_strobe && rx_last;

  if (TIMEOUT_CYC > 0) begin : g_timeout
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [IW-1:0] idle_cnt;

    // A strobe in the expiry cycle masks the timeout, so the byte is kept.
    assign expire = !bus.rx_strobe && (bus.rx_count != '0) &&
                    (idle_cnt == IW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        idle_cnt <= '0;
      end else if (bus.rx_strobe || (bus.rx_count == '0) || expire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end else begin : g_no_timeout
    assign expire = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc             <= '0;
      bus.rx_count    <= '0;
      bus.frame_data  <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      if (bus.rx_strobe) begin
        if (rx_last) begin
          bus.frame_data  <= acc_next;
          bus.frame_valid <= 1'b1;
          bus.rx_count    <= '0;
        end else begin
          acc          <= acc_next;
          bus.rx_count <= bus.rx_count + CW'(1);
        end
      end else if (expire) begin
        bus.rx_count  <= '0;
        bus.frame_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------- loopback
  logic          pend_full;
  logic [FW-1:0] pend_data;
  logic          lb_take;

  // A take and a new completion in the same cycle hand over cleanly: no overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full       <= 1'b0;
      pend_data       <= '0;
      bus.lb_overflow <= 1'b0;
    end else begin
      bus.lb_overflow <= 1'b0;
      if (lb_take) begin
        pend_full <= 1'b0;
      end
      if (rx_done && bus.loopback) begin
        if (pend_full && !lb_take) begin
          bus.lb_overflow <= 1'b1;
        end else begin
          pend_data <= acc_next;
          pend_full <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } tx_state_e;

  tx_state_e     state;
  logic [FW-1:0] tx_frame;
  logic [XW-1:0] idx;
  logic          ext_accept;

  assign ext_accept = bus.tx_frame_ready && bus.tx_frame_valid;
  assign lb_take    = (state == S_IDLE) && !ext_accept && bus.loopback && pend_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      tx_frame           <= '0;
      idx                <= '0;
      bus.tx_byte        <= '0;
      bus.tx_start       <= 1'b0;
      bus.tx_frame_ready <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (ext_accept) begin
            tx_frame           <= bus.tx_frame_data;
            bus.tx_frame_ready <= 1'b0;
            state              <= S_SEND;
          end else if (lb_take) begin
            tx_frame           <= pend_data;
            bus.tx_frame_ready <= 1'b0;
            state              <= S_SEND;
          end else begin
            bus.tx_frame_ready <= !bus.loopback;
          end
        end
        S_SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_byte  <= tx_frame[8*lane_of(int'(idx)) +: 8];
            bus.tx_start <= 1'b1;
            state        <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (bus.tx_busy) begin
            state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (idx == XW'(NBYTES - 1)) begin
              state              <= S_IDLE;
              bus.tx_frame_ready <= !bus.loopback;
            end else begin
              idx   <= idx + XW'(1);
              state <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_bridge.sv
// Self-checking bench: an LSB-first and an MSB-first bridge share RX stimulus and
// TX requests; results are compared against a frame-level reference model.
module tb_uart_frame_bridge;
  localparam int NB = 8;
  localparam int FW = NB * 8;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_bridge_if #(.NBYTES(NB)) b0 ();
  uart_frame_bridge_if #(.NBYTES(NB)) b1 ();

  uart_frame_bridge #(.NBYTES(NB), .TIMEOUT_CYC(TO), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  uart_frame_bridge #(.NBYTES(NB), .TIMEOUT_CYC(TO), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));

  int vectors = 0;
  int errors  = 0;
  int busy_cyc = 3;

  logic [FW-1:0] fq0[$], fq1[$];
  logic [7:0]    txq0[$], txq1[$];
  int err0 = 0, err1 = 0, ovf0 = 0, ovf_same = 0, start0 = 0, start1 = 0;

  // Reference model: frame word built from the byte sequence by lane arithmetic.
  function automatic logic [FW-1:0] pack(input logic [7:0] bytes[NB], input bit msb);
    logic [FW-1:0] f = '0;
    for (int i = 0; i < NB; i++) begin
      int l = msb ? (NB - 1 - i) : i;
      f = f | (FW'(bytes[i]) << (8 * l));
    end
    return f;
  endfunction

  function automatic logic [7:0] tx_exp(input logic [FW-1:0] f, input int i, input bit msb);
    int l = msb ? (NB - 1 - i) : i;
    return 8'(f >> (8 * l));
  endfunction

  // Output monitors
  always @(negedge clk) begin
    if (b0.frame_valid) fq0.push_back(b0.frame_data);
    if (b1.frame_valid) fq1.push_back(b1.frame_data);
    if (b0.frame_err) err0++;
    if (b1.frame_err) err1++;
    if (b0.lb_overflow) begin
      ovf0++;
      if (b0.frame_valid) ovf_same++;
    end
    if (b0.tx_start) start0++;
    if (b1.tx_start) start1++;
  end

  // Transmitter models: busy for busy_cyc cycles after each start pulse
  initial begin
    b0.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (b0.tx_start === 1'b1) begin
        txq0.push_back(b0.tx_byte);
        b0.tx_busy = 1'b1;
        for (int k = 0; k < busy_cyc && !rst; k++) @(negedge clk);
        b0.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    b1.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (b1.tx_start === 1'b1) begin
        txq1.push_back(b1.tx_byte);
        b1.tx_busy = 1'b1;
        for (int k = 0; k < busy_cyc && !rst; k++) @(negedge clk);
        b1.tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    b0.rx_strobe = 1'b1; b0.rx_byte = b;
    b1.rx_strobe = 1'b1; b1.rx_byte = b;
    if (gap > 0) begin
      @(negedge clk);
      b0.rx_strobe = 1'b0; b1.rx_strobe = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic rx_stop();
    @(negedge clk);
    b0.rx_strobe = 1'b0; b1.rx_strobe = 1'b0;
  endtask

  task automatic put_frame(input logic [FW-1:0] d);
    int n = 0;
    @(negedge clk);
    b0.tx_frame_data = d; b1.tx_frame_data = d;
    b0.tx_frame_valid = 1'b1; b1.tx_frame_valid = 1'b1;
    while (!(b0.tx_frame_ready && b1.tx_frame_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL put_frame: ready stayed low, got %b/%b required 1/1", b0.tx_frame_ready, b1.tx_frame_ready);
    end
    @(negedge clk);
    b0.tx_frame_valid = 1'b0; b1.tx_frame_valid = 1'b0;
  endtask

  task automatic wait_tx(input int nbytes, input int budget);
    int n = 0;
    while (!(txq0.size() >= nbytes && txq1.size() >= nbytes && !b0.tx_busy &&
             b0.tx_frame_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_tx: got %0d bytes, required %0d", txq0.size(), nbytes);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({b0.frame_valid, b0.frame_err, b0.tx_frame_ready, b0.tx_start, b0.lb_overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {b0.frame_valid, b0.frame_err, b0.tx_frame_ready, b0.tx_start, b0.lb_overflow});
    end
    vectors++;
    if (b0.frame_data !== '0 || b0.rx_count !== '0 || b0.tx_byte !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%0d/%h required 0/0/0", b0.frame_data, b0.rx_count, b0.tx_byte);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (b0.tx_frame_ready !== 1'b1 || b1.tx_frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b required 1/1", b0.tx_frame_ready, b1.tx_frame_ready);
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] b[NB];
    fq0.delete(); fq1.delete();
    for (int i = 0; i < NB; i++) b[i] = 8'(8'h11 * (i + 1));
    for (int i = 0; i < NB; i++) send_byte(b[i], 0);
    rx_stop();
    vectors++;
    if (b0.frame_valid !== 1'b1 || b0.frame_data !== 64'h8877665544332211) begin
      errors++;
      $display("FAIL rx_basic_lsb: got v=%b %h required v=1 8877665544332211", b0.frame_valid, b0.frame_data);
    end
    vectors++;
    if (b1.frame_data !== pack(b, 1'b1)) begin
      errors++;
      $display("FAIL rx_basic_msb: got %h required %h", b1.frame_data, pack(b, 1'b1));
    end
    @(negedge clk);
    vectors++;
    if (b0.frame_valid !== 1'b0 || b0.rx_count !== '0 || fq0.size() != 1) begin
      errors++;
      $display("FAIL rx_basic_pulse: got v=%b cnt=%0d frames=%0d required 0/0/1", b0.frame_valid, b0.rx_count, fq0.size());
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b[NB];
    int k_seen = -1;
    int e0 = err0;
    logic [FW-1:0] prev = b0.frame_data;
    fq0.delete();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    rx_stop();
    vectors++;
    if (b0.rx_count !== 4'd3) begin
      errors++;
      $display("FAIL timeout_partial_count: got %0d required 3", b0.rx_count);
    end
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (err0 != e0) begin
        k_seen = k;
        break;
      end
    end
    vectors++;
    if (k_seen < TO || k_seen > TO + 1 || err0 != e0 + 1) begin
      errors++;
      $display("FAIL timeout_err_pulse: got at idle cycle %0d (count %0d) required %0d (count %0d)", k_seen, err0 - e0, TO, 1);
    end
    vectors++;
    if (b0.rx_count !== '0 || b0.frame_data !== prev || fq0.size() != 0) begin
      errors++;
      $display("FAIL timeout_discard: got cnt=%0d data=%h frames=%0d required 0 %h 0", b0.rx_count, b0.frame_data, fq0.size(), prev);
    end
    // Strobe landing exactly in the expiry cycle keeps the byte
    for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
    e0 = err0;
    send_byte(b[0], 0);
    send_byte(b[1], 0);
    rx_stop();
    repeat (TO - 2) @(negedge clk);
    send_byte(b[2], 0);
    rx_stop();
    vectors++;
    if (b0.rx_count !== 4'd3 || err0 != e0) begin
      errors++;
      $display("FAIL timeout_strobe_wins: got cnt=%0d errs=%0d required 3 0", b0.rx_count, err0 - e0);
    end
    for (int i = 3; i < NB; i++) send_byte(b[i], 0);
    rx_stop();
    repeat (2) @(negedge clk);
    vectors++;
    if (fq0.size() != 1 || fq0[0] !== pack(b, 1'b0) || err0 != e0) begin
      errors++;
      $display("FAIL timeout_clean_frame: got n=%0d %h errs=%0d required 1 %h 0", fq0.size(), fq0[0], err0 - e0, pack(b, 1'b0));
    end
  endtask

  task automatic test_tx_basic();
    logic [FW-1:0] d = 64'h0807060504030201;
    int early = 0;
    int n = 0;
    txq0.delete(); txq1.delete();
    start0 = 0;
    busy_cyc = 20;
    put_frame(d);
    while (!(txq0.size() >= NB && !b0.tx_busy && b0.tx_frame_ready) && n < 1000) begin
      if (b0.tx_frame_ready) early++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (early != 0 || n >= 1000) begin
      errors++;
      $display("FAIL tx_ready_low: got %0d ready cycles mid-frame (waited %0d) required 0", early, n);
    end
    vectors++;
    if (start0 != NB || txq0.size() != NB) begin
      errors++;
      $display("FAIL tx_start_count: got %0d starts %0d bytes required %0d", start0, txq0.size(), NB);
    end
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (txq0[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL tx_basic_byte%0d: got %h required %h", i, txq0[i], 8'(i + 1));
      end
    end
    vectors++;
    if (txq1.size() != NB || txq1[0] !== 8'h08 || txq1[NB-1] !== 8'h01) begin
      errors++;
      $display("FAIL tx_basic_msb_order: got first %h last %h required 08 01", txq1[0], txq1[NB-1]);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] b[NB];
    fq1.delete(); txq1.delete();
    busy_cyc = 4;
    for (int i = 0; i < NB; i++) b[i] = 8'(8'hA1 + i);
    for (int i = 0; i < NB; i++) send_byte(b[i], 0);
    rx_stop();
    @(negedge clk);
    vectors++;
    if (fq1.size() != 1 || fq1[0] !== 64'hA1A2A3A4A5A6A7A8) begin
      errors++;
      $display("FAIL msb_rx_frame: got %h required A1A2A3A4A5A6A7A8", fq1[0]);
    end
    txq0.delete();
    put_frame(64'hA1A2A3A4A5A6A7A8);
    wait_tx(NB, 2000);
    vectors++;
    if (txq1[0] !== 8'hA1 || txq1[NB-1] !== 8'hA8 || txq0[0] !== 8'hA8) begin
      errors++;
      $display("FAIL msb_tx_order: got msb first %h last %h, lsb first %h required A1 A8 A8", txq1[0], txq1[NB-1], txq0[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0]    b[NB];
    logic [FW-1:0] e0[$], e1[$], t[$];
    fq0.delete(); fq1.delete(); txq0.delete(); txq1.delete();
    busy_cyc = $urandom_range(1, 6);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
      e0.push_back(pack(b, 1'b0));
      e1.push_back(pack(b, 1'b1));
      for (int i = 0; i < NB; i++) send_byte(b[i], $urandom_range(0, 5));
    end
    rx_stop();
    repeat (2) @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      vectors++;
      if (fq0.size() != 4 || fq0[f] !== e0[f] || fq1[f] !== e1[f]) begin
        errors++;
        $display("FAIL random_rx_frame%0d: got %h/%h required %h/%h", f, fq0[f], fq1[f], e0[f], e1[f]);
      end
    end
    for (int f = 0; f < 3; f++) begin
      t.push_back({$urandom, $urandom});
      put_frame(t[f]);
    end
    wait_tx(3 * NB, 5000);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NB; i++) begin
        vectors++;
        if (txq0[f*NB+i] !== tx_exp(t[f], i, 1'b0) || txq1[f*NB+i] !== tx_exp(t[f], i, 1'b1)) begin
          errors++;
          $display("FAIL random_tx_f%0d_b%0d: got %h/%h required %h/%h", f, i, txq0[f*NB+i], txq1[f*NB+i], tx_exp(t[f], i, 1'b0), tx_exp(t[f], i, 1'b1));
        end
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0]    b[NB];
    logic [FW-1:0] fr[3];
    int n = 0;
    fq0.delete(); txq0.delete();
    ovf0 = 0; ovf_same = 0; start0 = 0;
    busy_cyc = 2000;
    @(negedge clk);
    b0.loopback = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NB; i++) b[i] = 8'($urandom);
      fr[f] = pack(b, 1'b0);
      for (int i = 0; i < NB; i++) send_byte(b[i], 1);
    end
    rx_stop();
    repeat (2) @(negedge clk);
    vectors++;
    if (fq0.size() != 3 || ovf0 != 1 || ovf_same != 1) begin
      errors++;
      $display("FAIL lb_overflow: got frames=%0d ovf=%0d coincident=%0d required 3 1 1", fq0.size(), ovf0, ovf_same);
    end
    vectors++;
    if (b0.tx_frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL lb_ready_low: got %b required 0", b0.tx_frame_ready);
    end
    while (!(txq0.size() >= 2 * NB && !b0.tx_busy) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    b0.loopback = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (txq0.size() != 2 * NB || start0 != 2 * NB) begin
      errors++;
      $display("FAIL lb_byte_count: got %0d bytes %0d starts required %0d", txq0.size(), start0, 2 * NB);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NB; i++) begin
        vectors++;
        if (txq0[f*NB+i] !== tx_exp(fr[f], i, 1'b0)) begin
          errors++;
          $display("FAIL lb_f%0d_b%0d: got %h required %h", f, i, txq0[f*NB+i], tx_exp(fr[f], i, 1'b0));
        end
      end
    end
    vectors++;
    if (b0.tx_frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_exit_ready: got %b required 1", b0.tx_frame_ready);
    end
  endtask

  task automatic test_reset_midsend();
    int n = 0;
    int s;
    txq0.delete();
    start0 = 0;
    busy_cyc = 10;
    put_frame({$urandom, $urandom});
    while (start0 < 3 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({b0.frame_valid, b0.frame_err, b0.tx_frame_ready, b0.tx_start, b0.lb_overflow} !== 5'b0 ||
        b0.tx_byte !== '0 || b0.frame_data !== '0 || b0.rx_count !== '0 || start0 != 3) begin
      errors++;
      $display("FAIL reset_midsend_outputs: got flags=%b byte=%h starts=%0d required 00000 00 3",
               {b0.frame_valid, b0.frame_err, b0.tx_frame_ready, b0.tx_start, b0.lb_overflow}, b0.tx_byte, start0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (b0.tx_frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midsend_ready: got %b required 1", b0.tx_frame_ready);
    end
    s = start0;
    repeat (50) @(negedge clk);
    vectors++;
    if (start0 != s || txq0.size() != 3) begin
      errors++;
      $display("FAIL reset_midsend_no_resend: got %0d extra starts, %0d bytes required 0, 3", start0 - s, txq0.size());
    end
  endtask

  initial begin
    b0.rx_strobe = 1'b0; b0.rx_byte = '0; b0.loopback = 1'b0;
    b0.tx_frame_data = '0; b0.tx_frame_valid = 1'b0;
    b1.rx_strobe = 1'b0; b1.rx_byte = '0; b1.loopback = 1'b0;
    b1.tx_frame_data = '0; b1.tx_frame_valid = 1'b0;
    test_reset();
    test_rx_basic();
    test_timeout();
    test_tx_basic();
    test_msb_first();
    test_random();
    test_loopback();
    test_reset_midsend();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
